// File: rtl/div_controller.sv
// div_controller: control FSM for a repeated-subtraction divider.
// Sequences clear, operand loads and subtract iterations of an external
// datapath (A/B registers, subtractor, quotient counter). Flags divide-by-zero
// and keeps its own count of subtract iterations. Supports abort and a
// synchronous clear.
module div_controller #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] data,
  input  logic         cmp,
  output logic         dp_clear,
  output logic         ldA,
  output logic         ldB,
  output logic         sel,
  output logic         upQ,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_A,
    LOAD_B,
    SUB,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   iter_cnt_q, iter_cnt_d;
  logic           zero_q, zero_d;

  // State, iteration counter and zero-divisor flag registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      iter_cnt_q <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
      zero_q     <= zero_d;
    end
  end

  // Next-state and datapath strobes; abort and clear override the normal decode.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    zero_d     = zero_q;
    dp_clear   = 1'b0;
    ldA        = 1'b0;
    ldB        = 1'b0;
    sel        = 1'b0;
    upQ        = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    ready      = (state_q == IDLE);
    busy       = (state_q == CLR) || (state_q == LOAD_A) ||
                 (state_q == LOAD_B) || (state_q == SUB);

    case (state_q)
      IDLE: begin
        if (start) state_d = CLR;
      end
      CLR: begin
        dp_clear   = 1'b1;
        iter_cnt_d = '0;
        state_d    = LOAD_A;
      end
      LOAD_A: begin
        ldA     = 1'b1;
        sel     = 1'b0;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        ldB = 1'b1;
        if (data == '0) begin
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SUB;
        end
      end
      SUB: begin
        if (!cmp) begin
          ldA        = 1'b1;
          sel        = 1'b1;
          upQ        = 1'b1;
          iter_cnt_d = iter_cnt_q + W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        err     = zero_q;
        zero_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort only matters while busy: drop to IDLE and wipe the datapath,
    // leaving the iteration count as it stood.
    if (abort && busy) begin
      state_d    = IDLE;
      dp_clear   = 1'b1;
      ldA        = 1'b0;
      ldB        = 1'b0;
      sel        = 1'b0;
      upQ        = 1'b0;
      iter_cnt_d = iter_cnt_q;
      zero_d     = 1'b0;
    end

    // Clear holds the datapath in reset and silences every other strobe.
    if (clear) begin
      state_d    = IDLE;
      iter_cnt_d = '0;
      zero_d     = 1'b0;
      dp_clear   = 1'b1;
      ldA        = 1'b0;
      ldB        = 1'b0;
      sel        = 1'b0;
      upQ        = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
    end
  end

  assign iter_cnt = iter_cnt_q;

endmodule
